// File: rtl/regfiles_lite_pkg.sv
// Shared types and response codes for the regfiles_lite AXI4-Lite arbiter.
package regfiles_lite_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_AW_W,
      WR_B,
      RD_AR,
      RD_R,
      DONE
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requesting index at or after ptr, wrapping to 0.
module rr_arbiter #(
   parameter int N_REQ = 2,
   parameter int IDX_W = 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid
);

   int cand;

   // Scan from the farthest offset down so the nearest requester wins last.
   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      cand        = 0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         cand = (int'(ptr) + i) % N_REQ;
         if (req[IDX_W'(cand)]) begin
            grant                = '0;
            grant[IDX_W'(cand)]  = 1'b1;
            grant_idx            = IDX_W'(cand);
            grant_valid          = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfiles_lite_axil_arbiter.sv
// Shares one AXI4-Lite master between N_REQ register requesters, one
// single-beat transaction at a time, round-robin, with a one-cycle ack.
module regfiles_lite_axil_arbiter
   import regfiles_lite_pkg::*;
#(
   parameter int N_REQ  = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                       ACLK,
   input  logic                       ARESETN,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ-1:0]           req_we,
   input  logic [N_REQ*ADDR_W-1:0]    req_addr,
   input  logic [N_REQ*DATA_W-1:0]    req_wdata,
   input  logic [N_REQ*DATA_W/8-1:0]  req_wstrb,
   output logic [N_REQ-1:0]           req_ack,
   output logic [DATA_W-1:0]          rsp_rdata,
   output logic [1:0]                 rsp_resp,
   output logic [ADDR_W-1:0]          m_awaddr,
   output logic [2:0]                 m_awprot,
   output logic                       m_awvalid,
   input  logic                       m_awready,
   output logic [DATA_W-1:0]          m_wdata,
   output logic [DATA_W/8-1:0]        m_wstrb,
   output logic                       m_wvalid,
   input  logic                       m_wready,
   input  logic [1:0]                 m_bresp,
   input  logic                       m_bvalid,
   output logic                       m_bready,
   output logic [ADDR_W-1:0]          m_araddr,
   output logic [2:0]                 m_arprot,
   output logic                       m_arvalid,
   input  logic                       m_arready,
   input  logic [DATA_W-1:0]          m_rdata,
   input  logic [1:0]                 m_rresp,
   input  logic                       m_rvalid,
   output logic                       m_rready
);

   localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int STRB_W = DATA_W / 8;

   state_t               state;
   logic [IDX_W-1:0]     rr_ptr;
   logic [IDX_W-1:0]     grant_q;
   logic [N_REQ-1:0]     grant_oh_q;
   logic [ADDR_W-1:0]    addr_q;
   logic [DATA_W-1:0]    wdata_q;
   logic [STRB_W-1:0]    wstrb_q;

   logic [N_REQ-1:0]     arb_grant;
   logic [IDX_W-1:0]     arb_idx;
   logic                 arb_valid;
   logic                 aw_done;
   logic                 w_done;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr_arbiter (
      .req         (req_valid),
      .ptr         (rr_ptr),
      .grant       (arb_grant),
      .grant_idx   (arb_idx),
      .grant_valid (arb_valid)
   );

   // Address and data come straight from the capture registers, so they
   // cannot move while a valid is up.
   assign m_awaddr = addr_q;
   assign m_araddr = addr_q;
   assign m_awprot = 3'b000;
   assign m_arprot = 3'b000;
   assign m_wdata  = wdata_q;
   assign m_wstrb  = wstrb_q;

   assign aw_done = !m_awvalid || m_awready;
   assign w_done  = !m_wvalid  || m_wready;

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         grant_q    <= '0;
         grant_oh_q <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         m_awvalid  <= 1'b0;
         m_wvalid   <= 1'b0;
         m_bready   <= 1'b0;
         m_arvalid  <= 1'b0;
         m_rready   <= 1'b0;
         req_ack    <= '0;
         rsp_rdata  <= '0;
         rsp_resp   <= RESP_OKAY;
      end else begin
         req_ack <= '0;
         case (state)
            IDLE: begin
               if (arb_valid) begin
                  grant_q    <= arb_idx;
                  grant_oh_q <= arb_grant;
                  addr_q     <= req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
                  wdata_q    <= req_wdata[int'(arb_idx)*DATA_W +: DATA_W];
                  wstrb_q    <= req_wstrb[int'(arb_idx)*STRB_W +: STRB_W];
                  if (req_we[arb_idx]) begin
                     m_awvalid <= 1'b1;
                     m_wvalid  <= 1'b1;
                     state     <= WR_AW_W;
                  end else begin
                     m_arvalid <= 1'b1;
                     state     <= RD_AR;
                  end
               end
            end
            WR_AW_W: begin
               // AW and W retire independently; move on once both are gone.
               if (m_awready) m_awvalid <= 1'b0;
               if (m_wready)  m_wvalid  <= 1'b0;
               if (aw_done && w_done) begin
                  m_bready <= 1'b1;
                  state    <= WR_B;
               end
            end
            WR_B: begin
               if (m_bvalid) begin
                  m_bready <= 1'b0;
                  rsp_resp <= m_bresp;
                  req_ack  <= grant_oh_q;
                  state    <= DONE;
               end
            end
            RD_AR: begin
               if (m_arready) begin
                  m_arvalid <= 1'b0;
                  m_rready  <= 1'b1;
                  state     <= RD_R;
               end
            end
            RD_R: begin
               if (m_rvalid) begin
                  m_rready  <= 1'b0;
                  rsp_rdata <= m_rdata;
                  rsp_resp  <= m_rresp;
                  req_ack   <= grant_oh_q;
                  state     <= DONE;
               end
            end
            DONE: begin
               rr_ptr <= (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_regfiles_lite_axil_arbiter.sv
// Scoreboard bench: two requesters against a small AXI4-Lite slave model.
module tb_regfiles_lite_axil_arbiter;
   import regfiles_lite_pkg::*;

   localparam int N_REQ  = 2;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic tb_ACLK    = 1'b0;
   logic tb_ARESETN = 1'b0;
   always #5 tb_ACLK = ~tb_ACLK;

   logic [N_REQ-1:0]          req_valid;
   logic [N_REQ-1:0]          req_we;
   logic [N_REQ*ADDR_W-1:0]   req_addr;
   logic [N_REQ*DATA_W-1:0]   req_wdata;
   logic [N_REQ*DATA_W/8-1:0] req_wstrb;
   logic [N_REQ-1:0]          req_ack;
   logic [DATA_W-1:0]         rsp_rdata;
   logic [1:0]                rsp_resp;
   logic [ADDR_W-1:0]         m_awaddr, m_araddr;
   logic [2:0]                m_awprot, m_arprot;
   logic                      m_awvalid, m_awready, m_wvalid, m_wready;
   logic [DATA_W-1:0]         m_wdata, m_rdata;
   logic [3:0]                m_wstrb;
   logic [1:0]                m_bresp, m_rresp;
   logic                      m_bvalid, m_bready, m_arvalid, m_arready;
   logic                      m_rvalid, m_rready;

   regfiles_lite_axil_arbiter #(
      .N_REQ (N_REQ), .ADDR_W (ADDR_W), .DATA_W (DATA_W)
   ) dut (
      .ACLK (tb_ACLK), .ARESETN (tb_ARESETN),
      .req_valid (req_valid), .req_we (req_we), .req_addr (req_addr),
      .req_wdata (req_wdata), .req_wstrb (req_wstrb), .req_ack (req_ack),
      .rsp_rdata (rsp_rdata), .rsp_resp (rsp_resp),
      .m_awaddr (m_awaddr), .m_awprot (m_awprot), .m_awvalid (m_awvalid), .m_awready (m_awready),
      .m_wdata (m_wdata), .m_wstrb (m_wstrb), .m_wvalid (m_wvalid), .m_wready (m_wready),
      .m_bresp (m_bresp), .m_bvalid (m_bvalid), .m_bready (m_bready),
      .m_araddr (m_araddr), .m_arprot (m_arprot), .m_arvalid (m_arvalid), .m_arready (m_arready),
      .m_rdata (m_rdata), .m_rresp (m_rresp), .m_rvalid (m_rvalid), .m_rready (m_rready)
   );

   // Slave model: 64 words below 0x100, SLVERR above; optional W and B stalls.
   int          w_delay = 0;
   bit          b_hold  = 1'b0;
   int          b_count = 0;
   int          w_cnt;
   logic        aw_seen, w_seen, b_pend;
   logic [31:0] aw_addr_q, w_data_q, wr_addr, wr_data;
   logic [3:0]  w_strb_q, wr_strb;
   logic        aw_fire, w_fire;
   logic [31:0] slv_mem [0:63];

   assign m_awready = !aw_seen;
   assign m_wready  = !w_seen && (w_cnt >= w_delay);
   assign m_arready = !m_rvalid;
   assign aw_fire   = m_awvalid && m_awready;
   assign w_fire    = m_wvalid && m_wready;
   assign wr_addr   = aw_seen ? aw_addr_q : m_awaddr;
   assign wr_data   = w_seen ? w_data_q : m_wdata;
   assign wr_strb   = w_seen ? w_strb_q : m_wstrb;

   always @(posedge tb_ACLK or negedge tb_ARESETN) begin
      if (!tb_ARESETN) begin
         aw_seen <= 1'b0; w_seen <= 1'b0; b_pend <= 1'b0; w_cnt <= 0;
         aw_addr_q <= '0; w_data_q <= '0; w_strb_q <= '0;
         m_bvalid <= 1'b0; m_bresp <= 2'b00;
         m_rvalid <= 1'b0; m_rdata <= '0; m_rresp <= 2'b00;
         for (int k = 0; k < 64; k++) slv_mem[k] <= '0;
      end else begin
         if (w_fire) w_cnt <= 0;
         else if (m_wvalid) w_cnt <= w_cnt + 1;
         if (aw_fire) begin aw_seen <= 1'b1; aw_addr_q <= m_awaddr; end
         if (w_fire) begin w_seen <= 1'b1; w_data_q <= m_wdata; w_strb_q <= m_wstrb; end
         if ((aw_seen || aw_fire) && (w_seen || w_fire)) begin
            aw_seen <= 1'b0;
            w_seen  <= 1'b0;
            if (wr_addr < 32'h100)
               for (int b = 0; b < 4; b++)
                  if (wr_strb[b]) slv_mem[wr_addr[7:2]][8*b +: 8] <= wr_data[8*b +: 8];
            m_bresp <= (wr_addr < 32'h100) ? RESP_OKAY : RESP_SLVERR;
            if (b_hold) b_pend <= 1'b1;
            else m_bvalid <= 1'b1;
         end
         if (b_pend && !b_hold) begin b_pend <= 1'b0; m_bvalid <= 1'b1; end
         if (m_bvalid && m_bready) begin m_bvalid <= 1'b0; b_count <= b_count + 1; end
         if (m_arvalid && m_arready) begin
            m_rvalid <= 1'b1;
            m_rdata  <= (m_araddr < 32'h100) ? slv_mem[m_araddr[7:2]] : 32'hDEADBEEF;
            m_rresp  <= (m_araddr < 32'h100) ? RESP_OKAY : RESP_SLVERR;
         end
         if (m_rvalid && m_rready) m_rvalid <= 1'b0;
      end
   end

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_resp;
      bit          chk_lat;
   } op_t;

   op_t         drv_q0[$], drv_q1[$], exp_q0[$], exp_q1[$];
   int          ack_log[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          load_cyc [N_REQ];
   logic [31:0] ref_mem [0:63];
   bit          saw_split;
   int          b_before;
   bit          reached;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   // Pushes the op to its requester's drive queue and the expected result to the scoreboard.
   task automatic applyStimulus(input int r, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wstrb, input bit chk_lat);
      op_t op;
      bit  mapped;
      mapped     = addr < 32'h100;
      op.we      = we;
      op.addr    = addr;
      op.wdata   = wdata;
      op.wstrb   = wstrb;
      op.chk_lat = chk_lat;
      op.exp_resp  = mapped ? RESP_OKAY : RESP_SLVERR;
      op.exp_rdata = '0;
      if (we) begin
         if (mapped)
            for (int b = 0; b < 4; b++)
               if (wstrb[b]) ref_mem[addr[7:2]][8*b +: 8] = wdata[8*b +: 8];
      end else begin
         op.exp_rdata = mapped ? ref_mem[addr[7:2]] : 32'hDEADBEEF;
      end
      if (r == 0) begin drv_q0.push_back(op); exp_q0.push_back(op); end
      else begin drv_q1.push_back(op); exp_q1.push_back(op); end
   endtask

   task automatic loadNext(input int i);
      op_t op;
      bit  have;
      have = 1'b0;
      if (i == 0 && drv_q0.size() > 0) begin op = drv_q0.pop_front(); have = 1'b1; end
      if (i == 1 && drv_q1.size() > 0) begin op = drv_q1.pop_front(); have = 1'b1; end
      if (have) begin
         req_valid[i]            = 1'b1;
         req_we[i]               = op.we;
         req_addr[i*32 +: 32]    = op.addr;
         req_wdata[i*32 +: 32]   = op.wdata;
         req_wstrb[i*4 +: 4]     = op.wstrb;
         load_cyc[i]             = cyc;
      end else begin
         req_valid[i] = 1'b0;
      end
   endtask

   task automatic handleAck(input int i);
      op_t e;
      bit  have;
      have = 1'b0;
      if (i == 0 && exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
      if (i == 1 && exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
      if (!have) begin
         checkOutput("unexpected_ack", 32'd1, 32'd0);
      end else begin
         checkOutput("rsp_resp", 32'(rsp_resp), 32'(e.exp_resp));
         if (!e.we) checkOutput("rsp_rdata", rsp_rdata, e.exp_rdata);
         if (e.chk_lat) checkOutput("ack_latency", 32'(cyc - load_cyc[i]), 32'd3);
      end
   endtask

   // One cycle: sample at the falling edge, score acks, then reload requesters.
   task automatic tick();
      @(negedge tb_ACLK);
      cyc++;
      if (m_wvalid && !m_awvalid) saw_split = 1'b1;
      if (req_ack != '0) checkOutput("ack_onehot", 32'($countones(req_ack)), 32'd1);
      for (int i = 0; i < N_REQ; i++) begin
         if (req_ack[i]) begin
            ack_log.push_back(i);
            handleAck(i);
         end
         if (req_ack[i] || !req_valid[i]) loadNext(i);
      end
   endtask

   task automatic waitIdle(input string tag);
      bit done;
      done = 1'b0;
      for (int k = 0; k < 300 && !done; k++) begin
         tick();
         done = (drv_q0.size() == 0) && (drv_q1.size() == 0) &&
                (exp_q0.size() == 0) && (exp_q1.size() == 0) && (req_valid == '0);
      end
      checkOutput(tag, 32'(done), 32'd1);
   endtask

   initial begin
      req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      saw_split = 1'b0;
      for (int k = 0; k < 64; k++) ref_mem[k] = '0;
      repeat (3) tick();
      checkOutput("rst_ack", 32'(req_ack), 32'd0);
      checkOutput("rst_rdata", rsp_rdata, 32'd0);
      checkOutput("rst_resp", 32'(rsp_resp), 32'd0);
      checkOutput("rst_valids", 32'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}), 32'd0);
      checkOutput("prot", 32'({m_awprot, m_arprot}), 32'd0);
      tb_ARESETN = 1'b1;
      repeat (2) tick();

      // Single write then reads; requester 1 read leaves the pointer back at 0.
      applyStimulus(0, 1'b1, 32'h0, 32'h0101FFFF, 4'hF, 1'b1);
      waitIdle("t1_write_done");
      applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
      waitIdle("t1_read_done");
      applyStimulus(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
      waitIdle("t1_read1_done");

      ack_log.delete();
      applyStimulus(0, 1'b1, 32'h4, 32'hABCD0001, 4'hF, 1'b0);
      applyStimulus(1, 1'b1, 32'h8, 32'hDEAD0011, 4'hF, 1'b0);
      waitIdle("t2_writes_done");
      checkOutput("t2_count", 32'(ack_log.size()), 32'd2);
      if (ack_log.size() == 2) begin
         checkOutput("t2_first", 32'(ack_log[0]), 32'd0);
         checkOutput("t2_second", 32'(ack_log[1]), 32'd1);
      end
      applyStimulus(0, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0);
      applyStimulus(1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0);
      waitIdle("t2_reads_done");

      // Both requesters stay busy; grants must alternate starting from 0.
      ack_log.delete();
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 1'b1, 32'h10 + 32'(4*k), 32'hC0DE0000 + 32'(k), 4'hF, 1'b0);
         applyStimulus(1, 1'b1, 32'h30 + 32'(4*k), 32'h12345678 + 32'(k), (k == 2) ? 4'b0011 : 4'hF, 1'b0);
      end
      waitIdle("t3_done");
      checkOutput("t3_count", 32'(ack_log.size()), 32'd6);
      for (int k = 0; k < ack_log.size(); k++)
         checkOutput("t3_order", 32'(ack_log[k]), 32'(k % 2));
      applyStimulus(0, 1'b0, 32'h38, 32'h0, 4'h0, 1'b0);
      applyStimulus(1, 1'b0, 32'h14, 32'h0, 4'h0, 1'b0);
      waitIdle("t3_readback");

      // W held off after AW: AW must retire first and exactly one B follows.
      w_delay   = 3;
      saw_split = 1'b0;
      b_before  = b_count;
      applyStimulus(0, 1'b1, 32'h20, 32'h55AA1234, 4'hF, 1'b0);
      waitIdle("t4_done");
      checkOutput("t4_split", 32'(saw_split), 32'd1);
      checkOutput("t4_b_count", 32'(b_count - b_before), 32'd1);
      w_delay = 0;
      applyStimulus(1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
      waitIdle("t4_readback");

      applyStimulus(0, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0);
      waitIdle("t5_done");
      tick();
      checkOutput("t5_idle", 32'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}), 32'd0);
      applyStimulus(1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0);
      waitIdle("t5_after");

      // Reset while waiting on B: everything drops and the aborted op gets no ack.
      b_hold  = 1'b1;
      reached = 1'b0;
      applyStimulus(0, 1'b1, 32'h24, 32'h00000077, 4'hF, 1'b0);
      for (int k = 0; k < 20 && !reached; k++) begin
         tick();
         reached = m_bready;
      end
      checkOutput("t6_reach_wr_b", 32'(reached), 32'd1);
      tb_ARESETN = 1'b0;
      #1;
      checkOutput("t6_valids", 32'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}), 32'd0);
      checkOutput("t6_ack", 32'(req_ack), 32'd0);
      drv_q0.delete();
      exp_q0.delete();
      req_valid = '0;
      for (int k = 0; k < 64; k++) ref_mem[k] = '0;
      repeat (3) tick();
      tb_ARESETN = 1'b1;
      b_hold     = 1'b0;
      repeat (4) tick();
      applyStimulus(0, 1'b1, 32'h28, 32'h600DF00D, 4'hF, 1'b1);
      waitIdle("t6_write");
      applyStimulus(0, 1'b0, 32'h28, 32'h0, 4'h0, 1'b1);
      waitIdle("t6_read");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
